// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// pipe_ctrl_pkg : shared types and control-vector encodings for pipe_hazard_ctrl
// Revision      : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

  localparam int RA_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FREEZE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  // Control vector order: {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush}
  localparam logic [5:0] c_CTRL_HOLD     = 6'b000000;
  localparam logic [5:0] c_CTRL_REDIRECT = 6'b111111;
  localparam logic [5:0] c_CTRL_LOAD_USE = 6'b001101;
  localparam logic [5:0] c_CTRL_FETCH_WT = 6'b011110;
  localparam logic [5:0] c_CTRL_STALE    = 6'b111110;
  localparam logic [5:0] c_CTRL_NORMAL   = 6'b111100;

endpackage

`default_nettype wire

// File: rtl/load_use_detect.sv
// ============================================================================
// load_use_detect : flags an ID-stage read of a register a load in EX will write
// Revision        : 1.0
// ============================================================================
`default_nettype none

module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int RA_W = RA_W_DEF
) (
  input  logic            ex_memread,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  output logic            hazard
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1 = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_hit_rs2 = id_use_rs2 && (id_rs2 == ex_rd);
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard    = ex_memread && (ex_rd != '0) && (w_hit_rs1 || w_hit_rs2);

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// pipe_hazard_ctrl : stall/flush sequencing for a 5-stage pipeline
// Optional perf counters with `define PIPE_CTRL_PERF_EN.  Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int IMEM_INFLIGHT = 1,
  parameter int RA_W          = RA_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_br_taken,
  input  logic            imem_valid,
  input  logic            dmem_busy,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            ifid_flush,
  output logic            idex_flush
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flush_count
`endif
);

  localparam logic [1:0] c_INFLIGHT = 2'(IMEM_INFLIGHT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_br_pend;
  logic       w_br_pend_nxt;
  logic [1:0] r_drain_cnt;
  logic [1:0] w_drain_cnt_nxt;
  logic [5:0] w_ctrl;
  logic       w_load_use;
  logic       w_br;
  logic       w_redirect;

  load_use_detect #(
    .RA_W (RA_W)
  ) u_load_use_detect (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .hazard     (w_load_use)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_br_pend   <= 1'b0;
      r_drain_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_br_pend   <= w_br_pend_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // A branch captured during a freeze is replayed as if live on the first free cycle
  assign w_br = ex_br_taken | r_br_pend;

  always_comb begin
    w_ctrl          = c_CTRL_NORMAL;
    w_state_nxt     = ST_RUN;
    w_br_pend_nxt   = 1'b0;
    w_drain_cnt_nxt = r_drain_cnt;
    w_redirect      = 1'b0;
    if (dmem_busy) begin
      w_ctrl        = c_CTRL_HOLD;
      w_state_nxt   = ST_FREEZE;
      w_br_pend_nxt = r_br_pend | ex_br_taken;
    end else if (w_br) begin
      w_ctrl          = c_CTRL_REDIRECT;
      w_redirect      = 1'b1;
      w_drain_cnt_nxt = c_INFLIGHT;
      w_state_nxt     = (c_INFLIGHT != 2'd0) ? ST_DRAIN : ST_RUN;
    end else begin
      w_state_nxt = (r_state == ST_DRAIN) ? ST_DRAIN : ST_RUN;
      if (w_load_use) begin
        w_ctrl = c_CTRL_LOAD_USE;
      end else if (!imem_valid) begin
        w_ctrl = c_CTRL_FETCH_WT;
      end else if (r_state == ST_DRAIN) begin
        // Fetch data still belongs to the wrong path: squash it and count it off
        w_ctrl          = c_CTRL_STALE;
        w_drain_cnt_nxt = 2'(r_drain_cnt - 2'd1);
        if (r_drain_cnt <= 2'd1) begin
          w_state_nxt = ST_RUN;
        end
      end
    end
  end

  always_comb begin
    {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush} = rst ? c_CTRL_HOLD : w_ctrl;
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= 32'd0;
      r_flush_count  <= 32'd0;
    end else begin
      if (!w_ctrl[5] && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_redirect && (r_flush_count != 32'hFFFF_FFFF)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// tb_pipe_hazard_ctrl : directed + random check of pipe_hazard_ctrl (IMEM_INFLIGHT=2)
// Revision            : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  localparam int IMEM_INFLIGHT = 2;
  localparam int RA_W          = 5;

  logic            clk;
  logic            rst;
  logic [RA_W-1:0] id_rs1;
  logic [RA_W-1:0] id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic            ex_memread;
  logic [RA_W-1:0] ex_rd;
  logic            ex_br_taken;
  logic            imem_valid;
  logic            dmem_busy;
  logic            pc_en;
  logic            ifid_en;
  logic            idex_en;
  logic            exmem_en;
  logic            ifid_flush;
  logic            idex_flush;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]     stall_cycles;
  logic [31:0]     flush_count;
`endif

  pipe_hazard_ctrl #(
    .IMEM_INFLIGHT (IMEM_INFLIGHT),
    .RA_W          (RA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .ex_br_taken (ex_br_taken),
    .imem_valid  (imem_valid),
    .dmem_busy   (dmem_busy),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  logic [5:0] obs;

  // Reference model: what the pipe owes us, tracked as events rather than states
  bit m_pend;
  int m_stale;
  int m_stalls;
  int m_flushes;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit br, input bit busy, input bit iv, input bit mr,
                      input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                      input bit u1, input bit u2, input string tag);
    logic [5:0] exp;
    bit         hz;
    bit         brx;
    @(negedge clk);
    rst = r; ex_br_taken = br; dmem_busy = busy; imem_valid = iv; ex_memread = mr;
    ex_rd = rd; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    #1;
    obs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush};
    if (r) begin
      exp = 6'b000000; m_pend = 0; m_stale = 0; m_stalls = 0; m_flushes = 0;
    end else if (busy) begin
      exp = 6'b000000; m_pend = m_pend | br; m_stale = 0; m_stalls++;
    end else begin
      brx = br | m_pend;
      m_pend = 0;
      hz = mr && (rd != 0) && ((u1 && r1 == rd) || (u2 && r2 == rd));
      if (brx) begin
        exp = 6'b111111; m_stale = IMEM_INFLIGHT; m_flushes++;
      end else if (hz) begin
        exp = 6'b001101; m_stalls++;
      end else if (!iv) begin
        exp = 6'b011110; m_stalls++;
      end else if (m_stale > 0) begin
        exp = 6'b111110; m_stale--;
      end else begin
        exp = 6'b111100;
      end
    end
    chk(tag, obs, exp);
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, tag);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "reset");
    step(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "reset");
  endtask

  initial begin
    rst = 1'b1; ex_br_taken = 0; dmem_busy = 0; imem_valid = 0; ex_memread = 0;
    ex_rd = '0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    m_pend = 0; m_stale = 0; m_stalls = 0; m_flushes = 0;

    do_reset();

    // Load-use on rs1: one bubble, then free flow
    step(0, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0, "loaduse");
    chk("loaduse_ctrl", {26'd0, obs}, 32'h0000_000D);
    idle("after_loaduse");
    chk("after_loaduse_ctrl", {26'd0, obs}, 32'h0000_003C);

    // Load into x0 is never a hazard
    step(0, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1, "x0_load");
    chk("x0_load_ctrl", {26'd0, obs}, 32'h0000_003C);

    // Redirect then two stale fetches, with a fetch bubble in between
    step(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "branch");
    chk("branch_ctrl", {26'd0, obs}, 32'h0000_003F);
    idle("stale1");
    chk("stale1_flush", {31'd0, obs[1]}, 32'd1);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "drain_wait");
    idle("stale2");
    chk("stale2_flush", {31'd0, obs[1]}, 32'd1);
    idle("drain_done");
    chk("drain_done_flush", {31'd0, obs[1]}, 32'd0);

    // Branch arrives mid-freeze and is replayed on release
    step(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "freeze1");
    step(0, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "freeze2");
    step(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "freeze3");
    chk("freeze3_ctrl", {26'd0, obs}, 32'd0);
    idle("freeze_release");
    chk("freeze_release_ctrl", {26'd0, obs}, 32'h0000_003F);
    idle("fr_stale1");
    idle("fr_stale2");
    idle("fr_run");

    // Reset with one stale fetch still owed
    step(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "rd_branch");
    idle("rd_stale1");
    step(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "rd_reset");
    idle("rd_after");
    chk("rd_after_flush", {31'd0, obs[1]}, 32'd0);

`ifdef PIPE_CTRL_PERF_EN
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, "perf_stall");
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, "perf_br");
      idle("perf_stale");
      idle("perf_stale");
    end
    @(negedge clk);
    chk("perf_stalls", stall_cycles, 32'd4);
    chk("perf_flushes", flush_count, 32'd2);
`endif

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
    end

`ifdef PIPE_CTRL_PERF_EN
    @(negedge clk);
    chk("rand_stalls", stall_cycles, 32'(m_stalls));
    chk("rand_flushes", flush_count, 32'(m_flushes));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter IMEM_INFLIGHT, default 1, range 0..3: number of stale fetch responses discarded after a redirect.
REQ-002 SHALL have parameter RA_W, default 5: register-address width.
REQ-003 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-005 SHALL have ports id_rs1, id_rs2  in  RA_W  source registers of the instruction in ID.
REQ-006 SHALL have ports id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2.
REQ-007 SHALL have ports ex_memread  in  1, and ex_rd  in  RA_W: EX holds a load writing ex_rd.
REQ-008 SHALL have port ex_br_taken  in  1  one-cycle pulse; branch/jump resolved taken in EX.
REQ-009 SHALL have port imem_valid  in  1  fetch data on the IF bus is valid this cycle.
REQ-010 SHALL have port dmem_busy  in  1  data memory not ready; whole pipe must hold.
REQ-011 SHALL have outputs pc_en, ifid_en, idex_en, exmem_en  out  1  stage-register enables.
REQ-012 SHALL have outputs ifid_flush, idex_flush  out  1  one-cycle bubble inserts into IF/ID and ID/EX.

Function
REQ-013 SHALL hold FSM states RUN, FREEZE, DRAIN; next-state registered, outputs Mealy from state and inputs.
REQ-014 SHALL detect load-use when ex_memread=1, ex_rd!=0, and (id_use_rs1 and id_rs1==ex_rd, or id_use_rs2 and id_rs2==ex_rd).
REQ-015 SHALL apply per-cycle priority: dmem_busy > taken branch (live or pending) > load-use > imem_valid=0 > normal.
REQ-016 SHALL, on dmem_busy=1 in any state: all enables 0, both flushes 0, go to FREEZE; ex_br_taken arriving then sets br_pend.
REQ-017 SHALL, in FREEZE with dmem_busy=0: resume RUN priority rules the same cycle, with br_pend treated as ex_br_taken, then clear br_pend.
REQ-018 SHALL, on taken branch: pc_en=1, ifid_flush=1, idex_flush=1, idex_en=1, exmem_en=1; load reload drain_cnt=IMEM_INFLIGHT; go to DRAIN if IMEM_INFLIGHT>0, else RUN.
REQ-019 SHALL, on load-use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1; exactly one bubble per detected hazard cycle.
REQ-020 SHALL, with imem_valid=0 and no higher event: pc_en=0, ifid_flush=1, idex_en=1, exmem_en=1.
REQ-021 SHALL, in DRAIN, treat each imem_valid=1 cycle as stale: ifid_flush=1, pc_en=1, drain_cnt decrements; return to RUN when it reaches 0.
REQ-022 SHALL restart DRAIN with drain_cnt=IMEM_INFLIGHT on a new taken branch while in DRAIN.
REQ-023 SHALL, in normal operation, drive all enables 1 and both flushes 0.
REQ-024 SHALL never assert ifid_flush and ifid_en=0 simultaneously except in reset.

Reset
REQ-025 SHALL, while rst=1: state RUN, br_pend=0, drain_cnt=0, all enables 0, both flushes 0.
REQ-026 SHALL, on rst asserted mid-FREEZE or mid-DRAIN, discard pending branch and drain count; first cycle after release behaves as RUN.

Configuration
REQ-027 SHALL, with PIPE_CTRL_PERF_EN defined, add outputs stall_cycles[31:0] (cycles with pc_en=0) and flush_count[31:0] (taken-branch redirects), saturating, zeroed on rst.
REQ-028 SHALL, without PIPE_CTRL_PERF_EN, omit those ports and counters; all other behaviour identical.

Structure
REQ-029 SHALL place the FSM state enum and RA_W default in shared package pipe_ctrl_pkg.
REQ-030 SHALL implement REQ-014 compare in combinational sub-module load_use_detect.

Verification
REQ-031 Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1.
REQ-032 x0 load: ex_rd=0, id_rs1=0 -> no stall, enables 1, flushes 0.
REQ-033 Branch, IMEM_INFLIGHT=2: ex_br_taken pulse -> both flushes 1 that cycle, then next two imem_valid cycles ifid_flush=1, then RUN.
REQ-034 Branch during freeze: dmem_busy=1 for 3 cycles, ex_br_taken in cycle 2 -> enables 0 for 3 cycles, redirect flush on cycle 4.
REQ-035 Reset mid-DRAIN: rst at drain_cnt=1 -> after release, first imem_valid cycle passes with ifid_flush=0.
REQ-036 Perf (PIPE_CTRL_PERF_EN): 4 stall cycles plus 2 redirects -> stall_cycles=4, flush_count=2.
